// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input and instruction-memory write port of instr_encoder_loader.
// master = bundle producer / memory side, slave = the encoder.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_f7b5;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata,
    output imem_ack
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm,
    output in_ready,
    output imem_we, imem_addr, imem_wdata,
    input  imem_ack
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I field bundles into instruction words and streams them into imem.
// Optional macro ENC_NOP_FILL_EN pads the rest of the session with NOPs on close.
module instr_encoder_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   finish,
  instr_encoder_loader_if.slave  bus,
  output logic [ADDR_W-1:0]      count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [3:0] {
    CL_LUI    = 4'd0,
    CL_AUIPC  = 4'd1,
    CL_JAL    = 4'd2,
    CL_JALR   = 4'd3,
    CL_BRANCH = 4'd4,
    CL_LOAD   = 4'd5,
    CL_STORE  = 4'd6,
    CL_OPIMM  = 4'd7,
    CL_OP     = 4'd8
  } instr_class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE
`ifdef ENC_NOP_FILL_EN
    , S_FILL
`endif
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fin_pend_q;
  logic [ADDR_W:0]   count_inc;
  logic              last_word;

  logic              take_word, reject, advance, close_req, fire_done;

  // ---------------------------------------------------------------- encoder
  logic signed [31:0] imm;
  logic [4:0]         rd, rs1, rs2;
  logic [2:0]         f3;
  logic               i_imm_ok, is_shift;
  logic [31:0]        enc_word;
  logic               enc_legal;

  assign imm      = $signed(bus.in_imm);
  assign rd       = bus.in_rd;
  assign rs1      = bus.in_rs1;
  assign rs2      = bus.in_rs2;
  assign f3       = bus.in_funct3;
  assign i_imm_ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    enc_word  = '0;
    enc_legal = 1'b0;
    case (bus.in_class)
      CL_LUI: begin
        enc_legal = (imm[11:0] == 12'd0);
        enc_word  = {imm[31:12], rd, 7'b0110111};
      end
      CL_AUIPC: begin
        enc_legal = (imm[11:0] == 12'd0);
        enc_word  = {imm[31:12], rd, 7'b0010111};
      end
      CL_JAL: begin
        enc_legal = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      CL_JALR: begin
        enc_legal = i_imm_ok;
        enc_word  = {imm[11:0], rs1, f3, rd, 7'b1100111};
      end
      CL_BRANCH: begin
        enc_legal = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
        enc_word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      end
      CL_LOAD: begin
        enc_legal = i_imm_ok;
        enc_word  = {imm[11:0], rs1, f3, rd, 7'b0000011};
      end
      CL_STORE: begin
        enc_legal = i_imm_ok;
        enc_word  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      end
      CL_OPIMM: begin
        if (is_shift) begin
          enc_legal = (imm >= 32'sd0) && (imm <= 32'sd31);
          enc_word  = {1'b0, bus.in_f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          enc_legal = i_imm_ok;
          enc_word  = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      CL_OP: begin
        enc_legal = 1'b1;
        enc_word  = {1'b0, bus.in_f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- control
  assign count_inc = {1'b0, count} + (ADDR_W+1)'(1);
  assign last_word = (count_inc == (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.imem_we  = 1'b0;
    busy         = 1'b0;
    take_word    = 1'b0;
    reject       = 1'b0;
    advance      = 1'b0;
    close_req    = 1'b0;
    fire_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        // finish outranks a bundle presented in the same cycle
        if (finish) begin
          close_req = 1'b1;
        end else if (bus.in_valid) begin
          if (enc_legal) begin
            take_word = 1'b1;
            state_d   = S_WRITE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        busy        = 1'b1;
        if (bus.imem_ack) begin
          advance = 1'b1;
          if (last_word || fin_pend_q || finish) close_req = 1'b1;
          else                                   state_d   = S_ACCEPT;
        end
      end
`ifdef ENC_NOP_FILL_EN
      S_FILL: begin
        bus.imem_we = 1'b1;
        busy        = 1'b1;
        if (bus.imem_ack) begin
          advance = 1'b1;
          if (last_word) begin
            state_d   = S_IDLE;
            fire_done = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (close_req) begin
`ifdef ENC_NOP_FILL_EN
      if (advance && last_word) begin
        state_d   = S_IDLE;
        fire_done = 1'b1;
      end else begin
        state_d = S_FILL;
      end
`else
      state_d   = S_IDLE;
      fire_done = 1'b1;
`endif
    end
  end

  // imem_we decodes the state register, so reset drops it without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      count      <= '0;
      wdata_q    <= '0;
      err        <= 1'b0;
      fin_pend_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= fire_done;
      if (state_q == S_IDLE && start) begin
        addr_q     <= base_addr & ~ADDR_W'(3);
        count      <= '0;
        err        <= 1'b0;
        fin_pend_q <= 1'b0;
      end
      if (take_word) wdata_q <= enc_word;
      if (reject)    err     <= 1'b1;
      if (advance) begin
        addr_q <= addr_q + ADDR_W'(4);
        count  <= count_inc[ADDR_W-1:0];
      end
      if (state_q == S_WRITE && finish) fin_pend_q <= 1'b1;
    end
  end

  assign bus.imem_addr = addr_q;
`ifdef ENC_NOP_FILL_EN
  assign bus.imem_wdata = (state_q == S_FILL) ? 32'h0000_0013 : wdata_q;
`else
  assign bus.imem_wdata = wdata_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: vector table, corner sequences,
// and random sessions against an arithmetic RV32I encoding model.
module tb_instr_encoder_loader;
  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] count;
  logic              busy, done, err;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .finish    (finish),
    .bus       (bus.slave),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               wr_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                stall_req = 0;
  int                done_cnt = 0;
  logic              done_prev = 1'b0;
  logic [ADDR_W-1:0] exp_addr;
  int                exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory side: acks after stall_req wait cycles and logs each accepted write.
  initial begin
    int stall_cnt = 0;
    bus.imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.imem_we) begin
        if (stall_cnt >= stall_req) begin
          bus.imem_ack = 1'b1;
          wr_q.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
          stall_cnt = 0;
        end else begin
          bus.imem_ack = 1'b0;
          stall_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_one_cycle", 32'(done_prev), 32'd0);
    end
    done_prev = done;
  end

  // Reference encoder built from field arithmetic on the immediate value.
  function automatic void ref_encode(input bundle_t b, output bit legal, output logic [31:0] w);
    int          s;
    logic [31:0] u, rdf, rs1f, rs2f, f3f, f7f;
    s    = b.imm;
    u    = b.imm;
    rdf  = 32'(b.rd)   << 7;
    rs1f = 32'(b.rs1)  << 15;
    rs2f = 32'(b.rs2)  << 20;
    f3f  = 32'(b.f3)   << 12;
    f7f  = 32'(b.f7b5) << 30;
    legal = 1'b0;
    w     = '0;
    case (b.cls)
      4'd0, 4'd1: begin
        legal = (u % 4096) == 0;
        w = (u / 4096) * 4096 + rdf + ((b.cls == 4'd0) ? 32'h37 : 32'h17);
      end
      4'd2: begin
        legal = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (s % 2 == 0);
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 32'hFF) << 12) | rdf | 32'h6F;
      end
      4'd3, 4'd5: begin
        legal = (s >= -2048) && (s <= 2047);
        w = ((u & 32'hFFF) << 20) | rs1f | f3f | rdf | ((b.cls == 4'd3) ? 32'h67 : 32'h03);
      end
      4'd4: begin
        legal = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | rs2f | rs1f | f3f
          | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      4'd6: begin
        legal = (s >= -2048) && (s <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | rs2f | rs1f | f3f | ((u & 32'h1F) << 7) | 32'h23;
      end
      4'd7: begin
        if (b.f3 == 3'd1 || b.f3 == 3'd5) begin
          legal = (s >= 0) && (s <= 31);
          w = f7f | ((u & 32'h1F) << 20) | rs1f | f3f | rdf | 32'h13;
        end else begin
          legal = (s >= -2048) && (s <= 2047);
          w = ((u & 32'hFFF) << 20) | rs1f | f3f | rdf | 32'h13;
        end
      end
      4'd8: begin
        legal = 1'b1;
        w = f7f | rs2f | rs1f | f3f | rdf | 32'h33;
      end
      default: ;
    endcase
  endfunction

  function automatic vec_t mk(input int cls, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7b5, input int imm,
                              input bit legal, input logic [31:0] word);
    vec_t v;
    v.b.cls  = 4'(cls);
    v.b.rd   = 5'(rd);
    v.b.rs1  = 5'(rs1);
    v.b.rs2  = 5'(rs2);
    v.b.f3   = 3'(f3);
    v.b.f7b5 = 1'(f7b5);
    v.b.imm  = 32'(imm);
    v.legal  = legal;
    v.word   = word;
    return v;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.cls  = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    b.rd   = 5'($urandom);
    b.rs1  = 5'($urandom);
    b.rs2  = 5'($urandom);
    b.f3   = 3'($urandom);
    b.f7b5 = 1'($urandom);
    case ($urandom_range(0, 3))
      0: b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: b.imm = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
      2: begin
        b.imm = $urandom;
        if ($urandom_range(0, 1) == 1) b.imm = b.imm & 32'hFFFF_F000;
      end
      default: b.imm = 32'($urandom_range(0, 40));
    endcase
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    bus.in_class  = b.cls;
    bus.in_rd     = b.rd;
    bus.in_rs1    = b.rs1;
    bus.in_rs2    = b.rs2;
    bus.in_funct3 = b.f3;
    bus.in_f7b5   = b.f7b5;
    bus.in_imm    = b.imm;
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr  = base & ~ADDR_W'(3);
    exp_count = 0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_err", 32'(err), 32'd0);
    check("start_count", 32'(count), 32'd0);
    check("start_addr", 32'(bus.imem_addr), 32'(exp_addr));
  endtask

  task automatic send_bundle(input bundle_t b, input bit legal, input logic [31:0] w,
                             input string tag);
    int n0 = wr_q.size();
    int waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    drive(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (legal) begin
      waited = 0;
      while (!(bus.in_ready || !busy) && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check({tag, "_nwrites"}, 32'(wr_q.size() - n0), 32'd1);
      if (wr_q.size() > n0) begin
        check({tag, "_addr"}, 32'(wr_q[n0].addr), 32'(exp_addr));
        check({tag, "_word"}, wr_q[n0].data, w);
      end
      exp_addr  = exp_addr + ADDR_W'(4);
      exp_count = exp_count + 1;
    end else begin
      @(negedge clk);
      check({tag, "_err"}, 32'(err), 32'd1);
      check({tag, "_nowrite"}, 32'(wr_q.size() - n0), 32'd0);
    end
    check({tag, "_count"}, 32'(count), 32'(exp_count));
  endtask

  task automatic wait_close(input int n0, input int d0, input string tag);
    int waited = 0;
    while (done_cnt == d0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_done"}, 32'(done_cnt), 32'(d0 + 1));
`ifdef ENC_NOP_FILL_EN
    check({tag, "_fill_n"}, 32'(wr_q.size() - n0), 32'(DEPTH - exp_count));
    for (int i = n0; i < wr_q.size(); i++) begin
      check({tag, "_fill_addr"}, 32'(wr_q[i].addr), 32'(exp_addr));
      check({tag, "_fill_word"}, wr_q[i].data, NOP);
      exp_addr = exp_addr + ADDR_W'(4);
    end
    exp_count = DEPTH;
`else
    check({tag, "_no_write"}, 32'(wr_q.size() - n0), 32'd0);
`endif
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic close_session(input string tag);
    int n0 = wr_q.size();
    int d0 = done_cnt;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    wait_close(n0, d0, tag);
  endtask

  initial begin
    vec_t    tbl[$];
    bundle_t b;
    bit      lg;
    logic [31:0] w;
    int      n0, d0, waited;

    bus.in_valid = 1'b0;
    drive('{cls: 4'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7b5: 1'b0, imm: 32'd0});

    tbl.push_back(mk(7, 1, 0, 0, 0, 0, 5, 1, 32'h0050_0093));
    tbl.push_back(mk(0, 5, 7, 9, 3, 1, 32'h1234_5000, 1, 32'h1234_52B7));
    tbl.push_back(mk(6, 9, 1, 2, 2, 0, 8, 1, 32'h0020_A423));
    tbl.push_back(mk(4, 0, 1, 2, 0, 0, -4, 1, 32'hFE20_8EE3));
    tbl.push_back(mk(2, 1, 3, 4, 0, 0, 8, 1, 32'h0080_00EF));
    tbl.push_back(mk(8, 3, 1, 2, 0, 1, 0, 1, 32'h4020_81B3));
    tbl.push_back(mk(7, 4, 1, 0, 5, 1, 3, 1, 32'h4030_D213));
    tbl.push_back(mk(7, 1, 0, 0, 0, 0, 2048, 0, 32'h0));
    tbl.push_back(mk(4, 0, 1, 2, 0, 0, 3, 0, 32'h0));
    tbl.push_back(mk(12, 1, 1, 1, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(7, 0, 0, 0, 0, 0, 2047, 1, 32'h7FF0_0013));
    tbl.push_back(mk(7, 0, 0, 0, 0, 0, -2048, 1, 32'h8000_0013));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 4094, 1, 32'h7E00_0FE3));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 4096, 0, 32'h0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 32'h000F_FFFE, 1, 32'h7FFF_F06F));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, -1048576, 1, 32'h8000_006F));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 32'h0010_0000, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h1234_5001, 0, 32'h0));
    tbl.push_back(mk(7, 1, 2, 0, 1, 0, 32, 0, 32'h0));
    tbl.push_back(mk(6, 0, 1, 2, 2, 0, -2049, 0, 32'h0));
    tbl.push_back(mk(15, 1, 1, 1, 0, 0, 0, 0, 32'h0));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // vector table in one session
    start_session(12'h100);
    foreach (tbl[i]) send_bundle(tbl[i].b, tbl[i].legal, tbl[i].word, $sformatf("vec%0d", i));
    check("err_sticky", 32'(err), 32'd1);
    close_session("vec_close");

    // long stall with finish raised mid-WRITE; base low bits ignored, address wraps
    start_session(12'hFFA);
    b = '{cls: 4'd8, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, f7b5: 1'b1, imm: 32'd0};
    stall_req = 5;
    n0 = wr_q.size();
    d0 = done_cnt;
    drive(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_we", 32'(bus.imem_we), 32'd1);
      check("stall_addr", 32'(bus.imem_addr), 32'(exp_addr));
      check("stall_wdata", bus.imem_wdata, 32'h4020_81B3);
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_no_done", 32'(done_cnt), 32'(d0));
      finish = (i == 1);
      @(negedge clk);
    end
    finish = 1'b0;
    waited = 0;
    while (wr_q.size() == n0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("stall_nwrites", 32'(wr_q.size() - n0), 32'd1);
    if (wr_q.size() > n0) check("stall_word_addr", 32'(wr_q[n0].addr), 32'(exp_addr));
    exp_addr  = exp_addr + ADDR_W'(4);
    exp_count = 1;
    wait_close(n0 + 1, d0, "stall_close");
    stall_req = 0;

    // fill to DEPTH: automatic close; start mid-session and finish in IDLE are ignored
    start_session(12'h200);
    d0 = done_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      b = rand_bundle();
      b.cls = 4'd8;
      ref_encode(b, lg, w);
      send_bundle(b, lg, w, "full");
      if (i == 2) begin
        base_addr = 12'h000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_addr", 32'(bus.imem_addr), 32'(exp_addr));
        check("start_ignored_count", 32'(count), 32'(exp_count));
      end
    end
    @(negedge clk);
    check("full_done", 32'(done_cnt), 32'(d0 + 1));
    check("full_idle", 32'(busy), 32'd0);
    check("full_count", 32'(count), 32'(DEPTH));
    d0 = done_cnt;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    check("idle_finish_ignored", 32'(done_cnt), 32'(d0));
    check("count_held", 32'(count), 32'(DEPTH));

    // random sessions against the model
    for (int s = 0; s < 8; s++) begin
      int nb = $urandom_range(1, 24);
      bit closed = 1'b0;
      start_session(ADDR_W'($urandom));
      for (int k = 0; k < nb && !closed; k++) begin
        stall_req = $urandom_range(0, 2);
        b = rand_bundle();
        ref_encode(b, lg, w);
        send_bundle(b, lg, w, $sformatf("rnd%0d_%0d", s, k));
        if (exp_count == DEPTH) begin
          @(negedge clk);
          check("rnd_auto_close", 32'(busy), 32'd0);
          closed = 1'b1;
        end
      end
      if (!closed) close_session("rnd_close");
    end
    stall_req = 0;

    // reset during a stalled write
    start_session(12'h040);
    stall_req = 10;
    drive('{cls: 4'd7, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7b5: 1'b0, imm: 32'd5});
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_we", 32'(bus.imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(bus.imem_we), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    stall_req = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Assembles RV32I instruction words from decoded fields and writes them one by one into instruction memory at consecutive word addresses. It uses the same opcode classes and immediate formats as the core's instruction decode, run in reverse. Testbenches and boot logic use it to build a program image before the core is released from reset. It has a valid/ready field input and a stall-capable memory write port with an ack.

Parameters:
ADDR_W, 12, byte-address width of imem_addr
DEPTH, 1024, maximum words written per session (start to finish)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; opens a session at base_addr
base_addr  in  ADDR_W  first byte address; bits [1:0] ignored and treated as 0
finish  in  1  pulse; closes the session
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP; 9-15 illegal
in_rd, in_rs1, in_rs2  in  5 each  register fields
in_funct3  in  3  funct3
in_f7b5  in  1  funct7 bit 5 (OP, and OPIMM shifts)
in_imm  in  32  signed immediate value (byte offset for JAL/BRANCH)
imem_we  out  1  write request
imem_addr  out  ADDR_W  byte address
imem_wdata  out  32  encoded word
imem_ack  in  1  write accepted this cycle
count  out  ADDR_W  words written this session
busy  out  1  session open
done  out  1  one-cycle pulse when a session closes
err  out  1  sticky; set on a rejected bundle, cleared by start

Behaviour:
- Reset: FSM in IDLE; all outputs 0.
- FSM states: IDLE, ACCEPT, WRITE, FILL (FILL exists only with the optional feature).
- IDLE:
  - in_ready=0, busy=0.
  - start loads addr=base_addr, count=0, err=0, then moves to ACCEPT.
  - finish is ignored.
- ACCEPT:
  - in_ready=1, busy=1.
  - A handshake (in_valid && in_ready) encodes the bundle combinationally.
  - A legal bundle: its word is registered into imem_wdata, then move to WRITE.
  - An illegal bundle: err is set, nothing is written, stay in ACCEPT.
- Illegal-bundle rules:
  - class 9-15;
  - I/S immediate outside [-2048, 2047];
  - BRANCH immediate outside [-4096, 4094] or bit0 = 1;
  - JAL immediate outside [-2^20, 2^20-2] or bit0 = 1;
  - LUI/AUIPC with in_imm[11:0] != 0;
  - OPIMM funct3 001/101 with in_imm outside 0..31.
- Encoding fields:
  - opcode, rd, rs1, rs2 and funct3 sit in standard RV32I positions.
  - U: instr[31:12] = imm[31:12].
  - J: {imm[20], imm[10:1], imm[11], imm[19:12]}.
  - B: {imm[12], imm[10:5], ..., imm[4:1], imm[11]}.
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - OP: funct7 = {0, in_f7b5, 00000}.
  - OPIMM shifts: [31:25] = {0, in_f7b5, 00000}, [24:20] = shamt.
  - Fields a class does not use are forced to 0 (e.g. LUI has rs1 = 0).
- WRITE:
  - imem_we=1; imem_addr and imem_wdata are held stable until imem_ack.
  - On ack: addr += 4 (wraps modulo 2^ADDR_W), count += 1, imem_we drops the next cycle.
  - Then: if count reaches DEPTH, close the session; otherwise return to ACCEPT.
  - Back-to-back throughput is 1 word per 2 cycles with zero-wait ack.
- finish:
  - In ACCEPT, finish closes the session. If finish and in_valid arrive together, finish wins and the bundle is not accepted.
  - In WRITE, finish is latched and takes effect once the ack completes.
- Session close: done pulses for 1 cycle and the FSM returns to IDLE. count holds its value until the next start.
- start outside IDLE is ignored.
- Reset mid-WRITE aborts immediately: imem_we drops asynchronously.

Optional Feature:
ENC_NOP_FILL_EN:
- Defined: closing a session goes through FILL first. FILL writes 0x00000013 (addi x0,x0,0) at successive addresses, same ack handshake, until count = DEPTH; then done pulses.
- Undefined: no FILL state; the session closes immediately.

Test Plan:
- start base 0x100; OPIMM rd1 rs1 0 f3 000 imm 5 -> imem_wdata 0x00500093 at 0x100; count 1.
- LUI rd5 imm 0x12345000 -> 0x123452B7. STORE rs1 1 rs2 2 f3 010 imm 8 -> 0x0020A423 at next address 0x104/0x108.
- BRANCH rs1 1 rs2 2 f3 000 imm -4 -> 0xFE208EE3. JAL rd1 imm 8 -> 0x008000EF. OP rd3 rs1 1 rs2 2 f7b5 1 -> 0x402081B3. OPIMM f3 101 rd4 rs1 1 imm 3 f7b5 1 -> 0x4030D213.
- OPIMM imm 2048, BRANCH imm 3, class 12 -> err=1, no imem_we, count unchanged. Next legal bundle is still written.
- imem_ack held low for 5 cycles -> addr/wdata stable, in_ready=0. finish asserted mid-WRITE -> done pulses only after the ack.
- DEPTH=4 -> 4 writes, then automatic done. With ENC_NOP_FILL_EN, DEPTH=4, 1 word then finish -> 3 NOPs at +4, +8, +12, then done.
